// File: rtl/iram_pkg.sv
// iram_pkg: shared FSM state encodings and geometry helpers for the instruction RAM.
// Parity width follows IRAM_PARITY_EN (one bit per byte lane when defined, none otherwise).
package iram_pkg;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction

    function automatic int off_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int par_w(input int dw);
`ifdef IRAM_PARITY_EN
        return dw / 8;
`else
        return 0;
`endif
    endfunction
endpackage

// File: rtl/iram_array.sv
// iram_array: DEPTH x W storage with a bit-masked synchronous write and an enabled synchronous read.
// A read of the word being written in the same cycle returns the old contents.
module iram_array #(
    parameter int W     = 32,
    parameter int DEPTH = 8192,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wmask,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/iram_ctrl.sv
// iram_ctrl: handshaked instruction RAM with zero-init FSM, address fault reporting and write-first forwarding.
// Define IRAM_PARITY_EN to store per-byte even parity and expose the inj_par fault-injection port.
module iram_ctrl
    import iram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8192,
    parameter int ADDR_W    = 32,
    parameter int INIT_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_ready,
    output logic                wr_err
`ifdef IRAM_PARITY_EN
    ,
    input  logic [DATA_W/8-1:0] inj_par
`endif
);
    localparam int L  = lanes(DATA_W);
    localparam int OB = off_bits(DATA_W);
    localparam int W  = DATA_W + par_w(DATA_W);
    localparam int IW = $clog2(DEPTH);

    logic [0:0]    state;
    logic [IW-1:0] init_idx, if_idx, wr_idx;
    logic          run, if_bad, wr_bad, if_acc, wr_acc, wr_do, hit, clr;
    logic          zero_q, aerr_q, perr;
    logic [W-1:0]  wword, wmask, arr_rdata, fwd_mask, fwd_word, merged;

    assign run       = state == RUN;
    assign init_done = run;
    assign if_ready  = run;
    assign wr_ready  = run;

    assign if_bad = ((if_addr & ADDR_W'(L - 1)) != '0) || ((if_addr >> OB) >= ADDR_W'(DEPTH));
    assign wr_bad = ((wr_addr & ADDR_W'(L - 1)) != '0) || ((wr_addr >> OB) >= ADDR_W'(DEPTH));
    assign if_idx = IW'(if_addr >> OB);
    assign wr_idx = IW'(wr_addr >> OB);
    assign if_acc = if_req & run & ~rst;
    assign wr_acc = wr_en & run & ~rst;
    assign wr_do  = wr_acc & ~wr_bad;
    assign hit    = if_acc & ~if_bad & wr_do & (if_idx == wr_idx);
    assign clr    = ~run & ~rst & (INIT_ZERO != 0);

    // Parity bits sit above the data and share their byte lane's enable.
    always_comb begin
        wword = '0;
        wmask = '0;
        wword[DATA_W-1:0] = wr_data;
        for (int b = 0; b < L; b++) begin
            wmask[8*b +: 8] = {8{wr_be[b]}};
`ifdef IRAM_PARITY_EN
            wword[DATA_W+b] = (^wr_data[8*b +: 8]) ^ inj_par[b];
            wmask[DATA_W+b] = wr_be[b];
`endif
        end
    end

    iram_array #(.W(W), .DEPTH(DEPTH), .IW(IW)) u_array (
        .clk   (clk),
        .we    (clr | wr_do),
        .waddr (run ? wr_idx : init_idx),
        .wmask (run ? wmask : '1),
        .wdata (run ? wword : '0),
        .re    (if_acc & ~if_bad),
        .raddr (if_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_idx <= '0;
        end else if (!run) begin
            if (INIT_ZERO == 0 || init_idx == IW'(DEPTH - 1)) state <= RUN;
            init_idx <= init_idx + 1'b1;
        end
    end

    // Response state only moves on an accepted fetch, so data holds between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid <= 1'b0;
            aerr_q    <= 1'b0;
            zero_q    <= 1'b1;
            wr_err    <= 1'b0;
            fwd_mask  <= '0;
            fwd_word  <= '0;
        end else begin
            if_rvalid <= if_acc;
            aerr_q    <= if_acc & if_bad;
            wr_err    <= wr_acc & wr_bad;
            if (if_acc) begin
                zero_q   <= if_bad;
                fwd_mask <= hit ? wmask : '0;
                fwd_word <= wword & wmask;
            end
        end
    end

    assign merged   = (arr_rdata & ~fwd_mask) | (fwd_word & fwd_mask);
    assign if_rdata = zero_q ? '0 : merged[DATA_W-1:0];

    always_comb begin
        perr = 1'b0;
`ifdef IRAM_PARITY_EN
        for (int b = 0; b < L; b++) perr = perr | ((^merged[8*b +: 8]) != merged[DATA_W+b]);
`endif
    end

    assign if_err = if_rvalid & (aerr_q | perr);
endmodule

// File: tb/tb_iram_ctrl.sv
// tb_iram_ctrl: directed self-checking bench for iram_ctrl with DEPTH=16.
// Parity steps are compiled only when IRAM_PARITY_EN is defined.
module tb_iram_ctrl;
    logic        clk = 1'b0;
    logic        rst, init_done, if_req, if_ready, if_rvalid, if_err;
    logic        wr_en, wr_ready, wr_err;
    logic [31:0] if_addr, if_rdata, wr_addr, wr_data;
    logic [3:0]  wr_be;
`ifdef IRAM_PARITY_EN
    logic [3:0]  inj_par;
`endif
    int checks = 0;
    int errors = 0;
    int n;
    logic seen;

    iram_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .INIT_ZERO(1)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_err(wr_err)
`ifdef IRAM_PARITY_EN
        , .inj_par(inj_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        if_req = 1'b1; if_addr = a;
        step();
        if_req = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        n = 0; seen = 1'b0;
        while (!init_done && n < 100) begin
            step();
            seen = seen | if_rvalid;
            n++;
        end
        chk(tag, n, 16);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
`ifdef IRAM_PARITY_EN
        inj_par = '0;
`endif
        step(); step();
        chk("rst_init_done", init_done, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rvalid", if_rvalid, 0);
        chk("rst_rdata", if_rdata, 0);
        chk("rst_if_err", if_err, 0);
        chk("rst_wr_err", wr_err, 0);
        rst = 1'b0;
        wait_init("init_cycles");
        chk("ready_after_init", {if_ready, wr_ready}, 2'b11);

        fetch(32'h3C);
        chk("zero_rvalid", if_rvalid, 1);
        chk("zero_rdata", if_rdata, 0);
        chk("zero_err", if_err, 0);

        write(32'h10, 4'hF, 32'hDEADBEEF);
        chk("wr_ok_err", wr_err, 0);
        if_req = 1'b1; if_addr = 32'h10; step();
        chk("b2b0_rvalid", if_rvalid, 1);
        chk("b2b0_rdata", if_rdata, 32'hDEADBEEF);
        if_addr = 32'h14; step();
        chk("b2b1_rvalid", if_rvalid, 1);
        chk("b2b1_rdata", if_rdata, 0);
        if_addr = 32'h10; step();
        chk("b2b2_rvalid", if_rvalid, 1);
        chk("b2b2_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0; step();
        chk("idle_rvalid", if_rvalid, 0);
        chk("idle_hold", if_rdata, 32'hDEADBEEF);

        wr_en = 1'b1; wr_addr = 32'h10; wr_be = 4'b0011; wr_data = 32'h0000_1234;
        fetch(32'h10);
        wr_en = 1'b0;
        chk("fwd_rdata", if_rdata, 32'hDEAD1234);
        chk("fwd_err", if_err, 0);
        fetch(32'h10);
        chk("fwd_stored", if_rdata, 32'hDEAD1234);

        write(32'h10, 4'b0000, 32'hFFFF_FFFF);
        fetch(32'h10);
        chk("be0_nochange", if_rdata, 32'hDEAD1234);

        fetch(32'h12);
        chk("mis_rvalid", if_rvalid, 1);
        chk("mis_err", if_err, 1);
        chk("mis_rdata", if_rdata, 0);
        fetch(32'h40);
        chk("oor_rvalid", if_rvalid, 1);
        chk("oor_err", if_err, 1);
        chk("oor_rdata", if_rdata, 0);
        write(32'h40, 4'hF, 32'hFFFF_FFFF);
        chk("oor_wr_err", wr_err, 1);
        step();
        chk("wr_err_pulse", wr_err, 0);
        write(32'h12, 4'hF, 32'hFFFF_FFFF);
        chk("mis_wr_err", wr_err, 1);
        fetch(32'h0);
        chk("oor_no_alias", if_rdata, 0);
        chk("good_err_clear", if_err, 0);
        fetch(32'h10);
        chk("mis_no_write", if_rdata, 32'hDEAD1234);

        rst = 1'b1; step(); rst = 1'b0;
        repeat (7) step();
        chk("mid_init_busy", init_done, 0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_rvalid", if_rvalid, 0);
        if_req = 1'b1; if_addr = 32'h10;
        wait_init("reinit_cycles");
        chk("req_in_init_ignored", seen, 0);
        if_req = 1'b0;
        fetch(32'h10);
        chk("reinit_zeroed", if_rdata, 0);

`ifdef IRAM_PARITY_EN
        inj_par = 4'b0100;
        write(32'h20, 4'hF, 32'hA5A5A5A5);
        inj_par = 4'b0000;
        fetch(32'h20);
        chk("par_bad_rdata", if_rdata, 32'hA5A5A5A5);
        chk("par_bad_err", if_err, 1);
        write(32'h20, 4'hF, 32'hA5A5A5A5);
        fetch(32'h20);
        chk("par_ok_err", if_err, 0);
        chk("par_ok_rdata", if_rdata, 32'hA5A5A5A5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
